assoc_cache_ctrl: RTL and testbench
===================================

ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

Parameters
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning word-address width.
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-003 The block SHALL have parameter WORDS_PER_BLOCK, default 4, meaning words per line (power of 2, >=2).
REQ-004 The block SHALL have parameter NUM_SETS, default 16, meaning sets of a 2-way set-associative array (power of 2).
REQ-005 Address split SHALL be offset = [log2(WORDS_PER_BLOCK)-1:0], index = next log2(NUM_SETS) bits, tag = remaining MSBs (>=1 bit).

Interface
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset; port clk is the single clock, and port reset is the asynchronous active-low reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous active-low reset.
REQ-009 WordAddress  in  ADDR_WIDTH  CPU word address.
REQ-010 DataIn  in  WIDTH  CPU write data.
REQ-011 mem_read / mem_write  in  1 each  CPU read/write request.
REQ-012 stall  out  1  CPU must hold request and wait.
REQ-013 DataOut  out  WIDTH  registered read data.
REQ-014 mm_addr  out  ADDR_WIDTH  main-memory word address.
REQ-015 mm_wdata  out  WIDTH  main-memory write data.
REQ-016 mm_rd_req / mm_wr_req  out  1 each  main-memory read/write request.
REQ-017 mm_rdata  in  WIDTH  main-memory read data.
REQ-018 mm_ready  in  1  one-cycle completion pulse for current main-memory word.

Function
REQ-019 FSM states SHALL be IDLE, REFILL, WRITE_MEM; requests are sampled only in IDLE; inputs are ignored in other states.
REQ-020 mem_read and mem_write both high SHALL be treated as a write.
REQ-021 Read hit (valid and tag match in either way of the set) SHALL load DataOut at the sampling edge, with stall low throughout (zero stall cycles).
REQ-022 Read miss SHALL assert stall combinationally in the request cycle, enter REFILL, and fetch words 0..WORDS_PER_BLOCK-1 of the block in ascending order, one outstanding mm_rd_req at a time.
REQ-023 In REFILL, mm_rd_req and mm_addr SHALL stay stable until mm_ready; each mm_ready writes mm_rdata into the victim line and advances the word counter.
REQ-024 On the last mm_ready, the block SHALL set valid and tag, load DataOut with the requested word, return to IDLE, and deassert stall the next cycle.
REQ-025 Victim selection SHALL be: invalid way 0, else invalid way 1, else the way named by the set's LRU bit.
REQ-026 Each set's LRU bit SHALL point to the other way after a read hit, a refill, or a write hit to a way.
REQ-027 Write (hit or miss) SHALL assert stall combinationally, enter WRITE_MEM, and drive mm_wr_req with mm_addr=WordAddress and mm_wdata=DataIn held until mm_ready (write-through).
REQ-028 Write hit SHALL also update the cached word at the sampling edge; write miss SHALL NOT allocate (no-write-allocate).
REQ-029 At most one of mm_rd_req and mm_wr_req SHALL be high at any time; both SHALL be low in IDLE.
REQ-030 DataOut SHALL hold its value except on a read hit or refill completion.

Reset
REQ-031 Reset low SHALL force, asynchronously: state IDLE, all valid bits 0, all LRU bits 0, word counter 0, stall 0, DataOut 0, mm_rd_req 0, mm_wr_req 0, mm_addr 0, mm_wdata 0.
REQ-032 Reset during REFILL or WRITE_MEM SHALL abandon the transaction; the partially filled line SHALL remain invalid.
REQ-033 Data and tag arrays SHALL NOT require reset.

Verification (defaults; memory preloaded with mem[i]=i+100; mm_ready 3 cycles after each request)
REQ-034 After reset, write DataIn=5 to addr 0x001 -> stall high, one mm_wr_req with addr 0x001, data 5; no allocation, so the next read of 0x001 misses.
REQ-035 Read 0x001 (miss) -> mm_rd_req for addrs 0x000..0x003 in order; DataOut=5 after completion; stall low the cycle after the 4th mm_ready.
REQ-036 Then read 0x003 -> hit, no mm_rd_req, stall never high, DataOut=103.
REQ-037 Write 15 to 0x001 (hit) -> mm_wr_req addr 0x001, data 15; a following read of 0x001 hits and returns 15.
REQ-038 LRU check: miss on 0x000, miss on 0x040 (same set, different tag), hit on 0x000, miss on 0x080 -> 0x040's way is evicted; then 0x000 hits and 0x040 misses.
REQ-039 Assert reset after the 2nd mm_ready of a refill -> stall=0, mm_rd_req=0, DataOut=0 immediately; re-reading the same address misses.

Source files
------------

// File: rtl/assoc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// assoc_cache_ctrl
//   2-way set-associative, write-through, no-write-allocate cache controller
//   sitting between a CPU word interface and a slow main memory that answers
//   each word request with a one-cycle mm_ready pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   WordAddress  CPU word address   (tag | index | offset)
//   DataIn       CPU write data
//   mem_read     CPU read request   (held while stall is high)
//   mem_write    CPU write request  (wins when both requests are high)
//   stall        CPU must hold its request and wait
//   DataOut      registered read data
//   mm_addr      main-memory word address
//   mm_wdata     main-memory write data
//   mm_rd_req    main-memory read request  (one word outstanding at a time)
//   mm_wr_req    main-memory write request
//   mm_rdata     main-memory read data
//   mm_ready     one-cycle completion pulse for the current memory word
// ---------------------------------------------------------------------------
module assoc_cache_ctrl #(
    parameter int ADDR_WIDTH      = 10,
    parameter int WIDTH           = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] WordAddress,
    input  logic [WIDTH-1:0]      DataIn,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  stall,
    output logic [WIDTH-1:0]      DataOut,
    output logic [ADDR_WIDTH-1:0] mm_addr,
    output logic [WIDTH-1:0]      mm_wdata,
    output logic                  mm_rd_req,
    output logic                  mm_wr_req,
    input  logic [WIDTH-1:0]      mm_rdata,
    input  logic                  mm_ready
);

    localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int LINE_W = IDX_W + OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        WRITE_MEM = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t                     r_state;
    logic [1:0][NUM_SETS-1:0]   r_valid;
    logic [NUM_SETS-1:0]        r_lru;        // way to evict when both are valid
    logic [OFF_W-1:0]           r_cnt;        // refill word counter
    logic                       r_fill_way;
    logic [TAG_W-1:0]           r_req_tag;
    logic [IDX_W-1:0]           r_req_idx;
    logic [OFF_W-1:0]           r_req_off;
    logic [WIDTH-1:0]           r_fill_word;  // requested word captured mid-refill
    logic [WIDTH-1:0]           r_data_out;
    logic [ADDR_WIDTH-1:0]      r_mm_addr;
    logic [WIDTH-1:0]           r_mm_wdata;
    logic                       r_mm_rd_req;
    logic                       r_mm_wr_req;

    // ---------------------------------------------------------------------
    // Address decode and lookup
    // ---------------------------------------------------------------------
    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [1:0]        w_way_hit;
    logic [WIDTH-1:0]  w_way_rdata [2];
    logic              w_hit;
    logic              w_hit_way;
    logic              w_victim;
    logic              w_is_write;
    logic              w_is_read;
    logic              w_last_word;
    logic [WIDTH-1:0]  w_fill_word;

    // Shared write port into the per-way arrays
    logic              w_data_we;
    logic              w_data_way;
    logic [LINE_W-1:0] w_data_waddr;
    logic [WIDTH-1:0]  w_data_wdata;
    logic              w_tag_we;

    assign w_off = WordAddress[OFF_W-1:0];
    assign w_idx = WordAddress[OFF_W +: IDX_W];
    assign w_tag = WordAddress[ADDR_WIDTH-1 -: TAG_W];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            logic [TAG_W-1:0] r_tag_mem  [NUM_SETS];
            logic [WIDTH-1:0] r_data_mem [NUM_SETS*WORDS_PER_BLOCK];

            // Tag/data contents are qualified by r_valid, so no reset needed
            always_ff @(posedge clk) begin
                if (w_tag_we && (r_fill_way == 1'(gi)))
                    r_tag_mem[r_req_idx] <= r_req_tag;
                if (w_data_we && (w_data_way == 1'(gi)))
                    r_data_mem[w_data_waddr] <= w_data_wdata;
            end

            assign w_way_hit[gi]   = r_valid[gi][w_idx] && (r_tag_mem[w_idx] == w_tag);
            assign w_way_rdata[gi] = r_data_mem[{w_idx, w_off}];
        end
    endgenerate

    assign w_hit      = |w_way_hit;
    assign w_hit_way  = w_way_hit[1];
    assign w_victim   = !r_valid[0][w_idx] ? 1'b0 :
                        !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_is_write = mem_write;
    assign w_is_read  = mem_read & ~mem_write;

    assign w_last_word = (r_cnt == OFF_W'(WORDS_PER_BLOCK - 1));
    // The requested word may arrive on the final beat, before it is registered
    assign w_fill_word = (r_cnt == r_req_off) ? mm_rdata : r_fill_word;

    always_comb begin
        w_data_we    = 1'b0;
        w_data_way   = 1'b0;
        w_data_waddr = '0;
        w_data_wdata = '0;
        if (reset) begin
            if (r_state == REFILL && mm_ready) begin
                w_data_we    = 1'b1;
                w_data_way   = r_fill_way;
                w_data_waddr = {r_req_idx, r_cnt};
                w_data_wdata = mm_rdata;
            end else if (r_state == IDLE && w_is_write && w_hit) begin
                w_data_we    = 1'b1;
                w_data_way   = w_hit_way;
                w_data_waddr = {w_idx, w_off};
                w_data_wdata = DataIn;
            end
        end
    end

    assign w_tag_we = reset && (r_state == REFILL) && mm_ready && w_last_word;

    // ---------------------------------------------------------------------
    // Stall: raised in the request cycle of a miss or write. In WRITE_MEM it
    // drops in the mm_ready cycle so the CPU retires the write at that edge
    // instead of re-issuing it from IDLE. A refill completes through the
    // read hit that follows in IDLE.
    // ---------------------------------------------------------------------
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE:      stall = w_is_write || (w_is_read && !w_hit);
                REFILL:    stall = 1'b1;
                WRITE_MEM: stall = !mm_ready;
                default:   stall = 1'b0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Controller FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_lru       <= '0;
            r_cnt       <= '0;
            r_fill_way  <= 1'b0;
            r_req_tag   <= '0;
            r_req_idx   <= '0;
            r_req_off   <= '0;
            r_fill_word <= '0;
            r_data_out  <= '0;
            r_mm_addr   <= '0;
            r_mm_wdata  <= '0;
            r_mm_rd_req <= 1'b0;
            r_mm_wr_req <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_is_write) begin
                        r_state     <= WRITE_MEM;
                        r_mm_wr_req <= 1'b1;
                        r_mm_addr   <= WordAddress;
                        r_mm_wdata  <= DataIn;
                        if (w_hit)
                            r_lru[w_idx] <= ~w_hit_way;
                    end else if (w_is_read) begin
                        if (w_hit) begin
                            r_data_out   <= w_way_rdata[w_hit_way];
                            r_lru[w_idx] <= ~w_hit_way;
                        end else begin
                            r_state     <= REFILL;
                            r_fill_way  <= w_victim;
                            r_req_tag   <= w_tag;
                            r_req_idx   <= w_idx;
                            r_req_off   <= w_off;
                            r_cnt       <= '0;
                            r_mm_rd_req <= 1'b1;
                            r_mm_addr   <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            // Victim is invalid while partially overwritten
                            r_valid[w_victim][w_idx] <= 1'b0;
                        end
                    end
                end

                REFILL: begin
                    if (mm_ready) begin
                        if (r_cnt == r_req_off)
                            r_fill_word <= mm_rdata;
                        if (w_last_word) begin
                            r_state                     <= IDLE;
                            r_mm_rd_req                 <= 1'b0;
                            r_valid[r_fill_way][r_req_idx] <= 1'b1;
                            r_lru[r_req_idx]            <= ~r_fill_way;
                            r_data_out                  <= w_fill_word;
                            r_cnt                       <= '0;
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_mm_addr <= {r_req_tag, r_req_idx, r_cnt + OFF_W'(1)};
                        end
                    end
                end

                WRITE_MEM: begin
                    if (mm_ready) begin
                        r_mm_wr_req <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign DataOut   = r_data_out;
    assign mm_addr   = r_mm_addr;
    assign mm_wdata  = r_mm_wdata;
    assign mm_rd_req = r_mm_rd_req;
    assign mm_wr_req = r_mm_wr_req;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_assoc_cache_ctrl
//   Self-checking bench for assoc_cache_ctrl: directed vector table, random
//   traffic against a recency-list reference model, and a mid-refill reset.
// ---------------------------------------------------------------------------
module tb_assoc_cache_ctrl;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int WPB = 4;
    localparam int NS  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] WordAddress = '0;
    logic [DW-1:0] DataIn = '0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic          stall;
    logic [DW-1:0] DataOut;
    logic [AW-1:0] mm_addr;
    logic [DW-1:0] mm_wdata;
    logic          mm_rd_req;
    logic          mm_wr_req;
    logic [DW-1:0] mm_rdata = '0;
    logic          mm_ready = 1'b0;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(
        .ADDR_WIDTH(AW), .WIDTH(DW), .WORDS_PER_BLOCK(WPB), .NUM_SETS(NS)
    ) dut (
        .clk(clk), .reset(reset),
        .WordAddress(WordAddress), .DataIn(DataIn),
        .mem_read(mem_read), .mem_write(mem_write),
        .stall(stall), .DataOut(DataOut),
        .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_rd_req(mm_rd_req), .mm_wr_req(mm_wr_req),
        .mm_rdata(mm_rdata), .mm_ready(mm_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Main memory: mem[i] = i + 100, answers 3 cycles after each request
    // ---------------------------------------------------------------------
    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];
    int            cyc = 0;
    int            rsp_cnt = 0;
    int            ready_cyc = 0;
    int            rd_ready_total = 0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_wdata;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        chk("mm_req_exclusive", 32'(mm_rd_req & mm_wr_req), 32'd0);
        if (!reset) begin
            mm_ready = 1'b0;
            rsp_cnt  = 0;
        end else if (mm_ready) begin
            mm_ready = 1'b0;
            rsp_cnt  = 0;
        end else if (mm_rd_req || mm_wr_req) begin
            if (rsp_cnt == 0) begin
                rsp_addr  = mm_addr;
                rsp_wdata = mm_wdata;
            end else begin
                chk("mm_addr_stable", 32'(mm_addr), 32'(rsp_addr));
            end
            rsp_cnt++;
            if (rsp_cnt == 3) begin
                mm_ready  = 1'b1;
                ready_cyc = cyc;
                if (mm_rd_req) begin
                    mm_rdata = mem[mm_addr];
                    rd_q.push_back(mm_addr);
                    rd_ready_total++;
                end else begin
                    chk("mm_wdata_stable", mm_wdata, rsp_wdata);
                    mem[mm_addr] = mm_wdata;
                    wr_addr_q.push_back(mm_addr);
                    wr_data_q.push_back(mm_wdata);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Reference model: per set, a 2-entry recency list of resident tags
    // (slot 0 most recent). Write-through keeps cached data equal to memory.
    // ---------------------------------------------------------------------
    int ref_list [NS][2];

    task automatic ref_reset();
        for (int s = 0; s < NS; s++) begin
            ref_list[s][0] = -1;
            ref_list[s][1] = -1;
        end
    endtask

    function automatic bit ref_resident(input logic [AW-1:0] a);
        int s = int'(a[5:2]);
        int t = int'(a[9:6]);
        return (ref_list[s][0] == t) || (ref_list[s][1] == t);
    endfunction

    // Mark as most recent; a newcomer pushes out the least recent tag
    task automatic ref_touch(input logic [AW-1:0] a);
        int s = int'(a[5:2]);
        int t = int'(a[9:6]);
        if (ref_list[s][0] != t) begin
            ref_list[s][1] = ref_list[s][0];
            ref_list[s][0] = t;
        end
    endtask

    // ---------------------------------------------------------------------
    // CPU-side transaction
    // ---------------------------------------------------------------------
    bit op_stalled;
    bit op_timeout;
    int op_done_cyc;

    task automatic do_op(input bit wr, input bit both, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit s;
        rd_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        WordAddress = a;
        DataIn      = d;
        mem_write   = wr;
        mem_read    = !wr || both;
        op_stalled  = 1'b0;
        op_timeout  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            s = stall;
            if (s) op_stalled = 1'b1;
            @(posedge clk);
            #1;
            if (!s) begin
                op_done_cyc = cyc;
                op_timeout  = 1'b0;
                break;
            end
            @(negedge clk);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic check_op(input string n, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit exp_miss, input logic [DW-1:0] exp_dout);
        int exp_rd;
        chk({n, ":timeout"}, 32'(op_timeout), 32'd0);
        chk({n, ":stall"}, 32'(op_stalled), 32'(wr || exp_miss));
        exp_rd = (!wr && exp_miss) ? WPB : 0;
        chk({n, ":rd_count"}, 32'(rd_q.size()), 32'(exp_rd));
        if (rd_q.size() == exp_rd) begin
            for (int j = 0; j < exp_rd; j++)
                chk({n, ":rd_addr"}, 32'(rd_q[j]), 32'({a[9:2], 2'(j)}));
        end
        chk({n, ":wr_count"}, 32'(wr_addr_q.size()), 32'(wr ? 1 : 0));
        if (wr && wr_addr_q.size() == 1) begin
            chk({n, ":wr_addr"}, 32'(wr_addr_q[0]), 32'(a));
            chk({n, ":wr_data"}, wr_data_q[0], d);
        end
        if (!op_timeout && (wr || exp_miss))
            chk({n, ":latency"}, 32'(op_done_cyc - ready_cyc), 32'(wr ? 1 : 2));
        chk({n, ":DataOut"}, DataOut, exp_dout);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reset     = 1'b0;
        #1;
        chk("rst:stall", 32'(stall), 32'd0);
        chk("rst:DataOut", DataOut, 32'd0);
        chk("rst:mm_rd_req", 32'(mm_rd_req), 32'd0);
        chk("rst:mm_wr_req", 32'(mm_wr_req), 32'd0);
        chk("rst:mm_addr", 32'(mm_addr), 32'd0);
        chk("rst:mm_wdata", mm_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ref_reset();
    endtask

    // ---------------------------------------------------------------------
    // Directed vectors: op 0 = read, 1 = write, 2 = reset
    // ---------------------------------------------------------------------
    typedef struct {
        int            op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            exp_miss;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_dout_cur;
        bit            wr;
        bit            both;
        bit            miss;
        int            start_rd;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'(i + 100);
            ref_mem[i] = 32'(i + 100);
        end
        ref_reset();

        tbl[0]  = '{1, 10'h001, 32'd5,  1'b0, 32'd0};    // write miss, no allocate
        tbl[1]  = '{0, 10'h001, 32'd0,  1'b1, 32'd5};    // read miss, refill 0..3
        tbl[2]  = '{0, 10'h003, 32'd0,  1'b0, 32'd103};  // hit in the same line
        tbl[3]  = '{1, 10'h001, 32'd15, 1'b0, 32'd103};  // write hit
        tbl[4]  = '{0, 10'h001, 32'd0,  1'b0, 32'd15};   // sees the written word
        tbl[5]  = '{2, 10'h000, 32'd0,  1'b0, 32'd0};
        tbl[6]  = '{0, 10'h000, 32'd0,  1'b1, 32'd100};
        tbl[7]  = '{0, 10'h040, 32'd0,  1'b1, 32'd164};  // same set, way 1
        tbl[8]  = '{0, 10'h000, 32'd0,  1'b0, 32'd100};  // 0x040 becomes LRU
        tbl[9]  = '{0, 10'h080, 32'd0,  1'b1, 32'd228};  // evicts 0x040
        tbl[10] = '{0, 10'h000, 32'd0,  1'b0, 32'd100};
        tbl[11] = '{0, 10'h040, 32'd0,  1'b1, 32'd164};
        tbl[12] = '{0, 10'h001, 32'd0,  1'b0, 32'd15};   // 0x000 line still resident

        do_reset();

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].op == 2) begin
                do_reset();
            end else begin
                wr = (tbl[i].op == 1);
                if (wr) ref_mem[tbl[i].addr] = tbl[i].data;
                do_op(wr, 1'b0, tbl[i].addr, tbl[i].data);
                check_op($sformatf("vec%0d", i), wr, tbl[i].addr, tbl[i].data,
                         tbl[i].exp_miss, tbl[i].exp_dout);
                $display("vec%0d op=%0d addr=0x%03h stall=%0d DataOut=%0d", i, tbl[i].op,
                         tbl[i].addr, op_stalled, DataOut);
            end
        end

        // Random traffic over a few sets and tags against the model
        do_reset();
        exp_dout_cur = '0;
        for (int i = 0; i < 150; i++) begin
            wr   = ($urandom_range(0, 99) < 30);
            both = wr && ($urandom_range(0, 1) == 1);
            a    = 10'($urandom_range(0, 3) * 64 + $urandom_range(0, 1) * 4 + $urandom_range(0, 3));
            d    = $urandom;
            miss = !ref_resident(a);
            if (wr) begin
                ref_mem[a] = d;
                if (!miss) ref_touch(a);
            end else begin
                ref_touch(a);
                exp_dout_cur = ref_mem[a];
            end
            do_op(wr, both, a, d);
            check_op($sformatf("rnd%0d", i), wr, a, d, miss, exp_dout_cur);
            $display("rnd%0d %s addr=0x%03h data=0x%08h miss=%0d DataOut=0x%08h", i,
                     wr ? "WR" : "RD", a, d, miss, DataOut);
        end

        // Reset in the middle of a refill abandons the line
        do_reset();
        do_op(1'b0, 1'b0, 10'h200, '0);
        ref_touch(10'h200);
        check_op("rst_pre", 1'b0, 10'h200, '0, 1'b1, ref_mem[10'h200]);
        start_rd = rd_ready_total;
        @(negedge clk);
        WordAddress = 10'h105;
        mem_read    = 1'b1;
        for (int i = 0; i < 100 && rd_ready_total < start_rd + 2; i++) @(negedge clk);
        chk("rst_mid:ready_count", 32'(rd_ready_total - start_rd), 32'd2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid:stall", 32'(stall), 32'd0);
        chk("rst_mid:mm_rd_req", 32'(mm_rd_req), 32'd0);
        chk("rst_mid:mm_wr_req", 32'(mm_wr_req), 32'd0);
        chk("rst_mid:DataOut", DataOut, 32'd0);
        $display("rst_mid stall=%0d mm_rd_req=%0d DataOut=%0d", stall, mm_rd_req, DataOut);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ref_reset();
        do_op(1'b0, 1'b0, 10'h105, '0);
        ref_touch(10'h105);
        check_op("rst_reread", 1'b0, 10'h105, '0, 1'b1, ref_mem[10'h105]);
        $display("rst_reread addr=0x105 stall=%0d DataOut=%0d", op_stalled, DataOut);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
